// File: rtl/fifo_pkg.sv
// Shared types and default widths for the FIFO control sequencer.
package fifo_pkg;

    localparam int unsigned DEF_B = 8;
    localparam int unsigned DEF_W = 3;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'b00,
        ST_NORMAL = 2'b01,
        ST_FULL   = 2'b11
    } fifo_state_t;

endpackage

// File: rtl/fifo_ctrl_rise_pulse.sv
// Rising-edge detector for a debounced button level.
module rise_pulse (
    input  logic clk,
    input  logic clr,
    input  logic i_req,
    output logic o_pulse
);

    logic r_req_q;

    // The level is tracked even during clr so a button held through reset
    // must be released and pressed again before it produces a pulse.
    always_ff @(posedge clk) begin
        r_req_q <= i_req;
    end

    assign o_pulse = i_req & ~r_req_q & ~clr;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control sequencer: button edges to read/write strobes, pointers,
// occupancy and sticky overflow/underflow flags.
//
// state     | meaning
// ST_EMPTY  | count == 0, reads rejected
// ST_NORMAL | 0 < count < 2**W
// ST_FULL   | count == 2**W, writes accepted only alongside a read
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned B = DEF_B,
    parameter int unsigned W = DEF_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         wr_req,
    input  logic         rd_req,
    output logic         wr_en,
    output logic         re_en,
    output logic [W-1:0] w_addr,
    output logic [W-1:0] r_addr,
    output logic [W:0]   count,
    output logic         full,
    output logic         empty,
    output logic         ovf,
    output logic         udf
);

    localparam logic [W:0] C_FULL = {1'b1, {W{1'b0}}};

    logic        w_wr_evt;
    logic        w_rd_evt;
    logic        w_wr_acc;
    logic        w_rd_acc;
    logic [W:0]  w_count_next;
    fifo_state_t w_state_next;

    logic         r_wr_en;
    logic         r_re_en;
    logic [W-1:0] r_w_addr;
    logic [W-1:0] r_r_addr;
    logic [W:0]   r_count;
    logic         r_ovf;
    logic         r_udf;
    fifo_state_t  r_state;

    rise_pulse u_wr_edge (
        .clk     (clk),
        .clr     (clr),
        .i_req   (wr_req),
        .o_pulse (w_wr_evt)
    );

    rise_pulse u_rd_edge (
        .clk     (clk),
        .clr     (clr),
        .i_req   (rd_req),
        .o_pulse (w_rd_evt)
    );

    // A write while full is only safe when a read frees a slot in the same cycle.
    always_comb begin
        w_rd_acc = 1'b0;
        w_wr_acc = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                w_wr_acc = w_wr_evt;
            end
            ST_NORMAL: begin
                w_wr_acc = w_wr_evt;
                w_rd_acc = w_rd_evt;
            end
            ST_FULL: begin
                w_rd_acc = w_rd_evt;
                w_wr_acc = w_wr_evt & w_rd_evt;
            end
            default: begin
                w_wr_acc = 1'b0;
                w_rd_acc = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        case ({r_wr_en, r_re_en})
            2'b10:   w_count_next = r_count + {{W{1'b0}}, 1'b1};
            2'b01:   w_count_next = r_count - {{W{1'b0}}, 1'b1};
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_state_next = ST_EMPTY;
        case (r_state)
            ST_EMPTY, ST_NORMAL, ST_FULL: begin
                if (w_count_next == '0)
                    w_state_next = ST_EMPTY;
                else if (w_count_next == C_FULL)
                    w_state_next = ST_FULL;
                else
                    w_state_next = ST_NORMAL;
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_wr_en  <= 1'b0;
            r_re_en  <= 1'b0;
            r_w_addr <= '0;
            r_r_addr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_state  <= ST_EMPTY;
        end else begin
            r_wr_en <= w_wr_acc;
            r_re_en <= w_rd_acc;
            // Pointers move at the end of their strobe cycle, so the address
            // is stable for the whole strobe.
            if (r_wr_en)
                r_w_addr <= r_w_addr + {{(W-1){1'b0}}, 1'b1};
            if (r_re_en)
                r_r_addr <= r_r_addr + {{(W-1){1'b0}}, 1'b1};
            r_count <= w_count_next;
            r_state <= w_state_next;
            if (w_wr_evt && !w_wr_acc)
                r_ovf <= 1'b1;
            if (w_rd_evt && !w_rd_acc)
                r_udf <= 1'b1;
        end
    end

    assign wr_en  = r_wr_en;
    assign re_en  = r_re_en;
    assign w_addr = r_w_addr;
    assign r_addr = r_r_addr;
    assign count  = r_count;
    assign full   = (r_state == ST_FULL);
    assign empty  = (r_state == ST_EMPTY);
    assign ovf    = r_ovf;
    assign udf    = r_udf;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: presses queue expected strobes, a negedge
// monitor pops and compares them; status is compared against a small model.
module tb_fifo_ctrl;

    localparam int W     = 3;
    localparam int DEPTH = 1 << W;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         wr_req = 1'b0;
    logic         rd_req = 1'b0;
    logic         wr_en;
    logic         re_en;
    logic [W-1:0] w_addr;
    logic [W-1:0] r_addr;
    logic [W:0]   count;
    logic         full;
    logic         empty;
    logic         ovf;
    logic         udf;

    fifo_ctrl #(.B(8), .W(W)) dut (
        .clk    (clk),
        .clr    (clr),
        .wr_req (wr_req),
        .rd_req (rd_req),
        .wr_en  (wr_en),
        .re_en  (re_en),
        .w_addr (w_addr),
        .r_addr (r_addr),
        .count  (count),
        .full   (full),
        .empty  (empty),
        .ovf    (ovf),
        .udf    (udf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int cyc;
    } exp_t;

    exp_t wr_q[$];
    exp_t rd_q[$];

    int errors = 0;
    int checks = 0;

    int m_cnt = 0;
    int m_wp  = 0;
    int m_rp  = 0;
    int m_ovf = 0;
    int m_udf = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", wr_en, 0);
            end else begin
                exp_t e;
                e = wr_q.pop_front();
                chk("wr_addr", w_addr, e.addr);
                chk("wr_latency", cyc, e.cyc);
            end
        end
        if (re_en === 1'b1) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", re_en, 0);
            end else begin
                exp_t e;
                e = rd_q.pop_front();
                chk("rd_addr", r_addr, e.addr);
                chk("rd_latency", cyc, e.cyc);
            end
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        clr = 1'b1;
        repeat (n) @(negedge clk);
        clr = 1'b0;
        m_cnt = 0;
        m_wp  = 0;
        m_rp  = 0;
        m_ovf = 0;
        m_udf = 0;
    endtask

    task automatic drive(input bit w, input bit r);
        bit wa;
        bit ra;
        @(negedge clk);
        ra = r && (m_cnt > 0);
        wa = w && ((m_cnt < DEPTH) || ra);
        if (w && !wa) m_ovf = 1;
        if (r && !ra) m_udf = 1;
        if (wa) begin
            wr_q.push_back('{addr: m_wp, cyc: cyc + 1});
            m_wp = (m_wp + 1) % DEPTH;
        end
        if (ra) begin
            rd_q.push_back('{addr: m_rp, cyc: cyc + 1});
            m_rp = (m_rp + 1) % DEPTH;
        end
        m_cnt = m_cnt + int'(wa) - int'(ra);
        wr_req = w;
        rd_req = r;
    endtask

    task automatic release_all();
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic press(input bit w, input bit r, input int hold);
        drive(w, r);
        repeat (hold) @(negedge clk);
        release_all();
    endtask

    task automatic check_status();
        chk("count", count, m_cnt);
        chk("full", full, (m_cnt == DEPTH) ? 1 : 0);
        chk("empty", empty, (m_cnt == 0) ? 1 : 0);
        chk("ovf", ovf, m_ovf);
        chk("udf", udf, m_udf);
        chk("w_addr", w_addr, m_wp);
        chk("r_addr", r_addr, m_rp);
    endtask

    initial begin
        // reset / idle
        do_reset(2);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_re_en", re_en, 0);
        repeat (20) @(negedge clk);
        check_status();

        // fill and wrap, then overflow
        for (int i = 0; i < DEPTH; i++) press(1, 0, 5);
        check_status();
        press(1, 0, 5);
        check_status();

        // drain, then underflow
        for (int i = 0; i < DEPTH; i++) press(0, 1, 5);
        check_status();
        press(0, 1, 5);
        check_status();

        // simultaneous at count=3
        do_reset(2);
        for (int i = 0; i < 3; i++) press(1, 0, 5);
        press(1, 1, 5);
        check_status();

        // simultaneous when empty
        do_reset(2);
        press(1, 1, 5);
        check_status();

        // simultaneous when full
        do_reset(2);
        for (int i = 0; i < DEPTH; i++) press(1, 0, 4);
        press(1, 1, 5);
        check_status();

        // write button held through reset
        do_reset(2);
        press(1, 0, 5);
        drive(1, 0);
        repeat (4) @(negedge clk);
        do_reset(2);
        repeat (10) @(negedge clk);
        check_status();
        release_all();
        press(1, 0, 5);
        check_status();

        // long hold produces a single strobe
        press(1, 0, 100);
        check_status();

        repeat (5) @(negedge clk);
        chk("wr_q_left", wr_q.size(), 0);
        chk("rd_q_left", rd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Control sequencer for the FIFO register file.
- Converts the two debounced push-button levels (read, write) into single-cycle read/write enables.
- Maintains the write and read pointers, occupancy count and full/empty status.
- Guards the register file against overflow and underflow, and flags any attempt as a sticky error.
- Sits between the two DeBounce instances and the reg_file; count and status also feed the seven-segment display path.

Parameters:
B, 8, data width (passed through only for display/width consistency; no datapath inside)
W, 3, address bits; FIFO depth = 2**W

Ports:
clk  input  1  system clock, all logic on rising edge
clr  input  1  synchronous active-high reset
wr_req  input  1  debounced write button level
rd_req  input  1  debounced read button level
wr_en  output  1  one-cycle write strobe to reg_file
re_en  output  1  one-cycle read strobe to reg_file
w_addr  output  W  write pointer to reg_file
r_addr  output  W  read pointer to reg_file
count  output  W+1  occupancy, 0..2**W
full  output  1  count == 2**W
empty  output  1  count == 0
ovf  output  1  sticky: write attempted while full
udf  output  1  sticky: read attempted while empty

Behaviour:
Reset:
- clr is synchronous and has priority over all other activity, including mid-operation.
- On the clr edge: wr_en=0, re_en=0, w_addr=0, r_addr=0, count=0, empty=1, full=0, ovf=0, udf=0, state=EMPTY.
- During clr, req_q registers load the current req levels, so a button held through clr produces no pulse until it is released and pressed again.

Edge detect:
- wr_evt = wr_req & ~wr_req_q; rd_evt = rd_req & ~rd_req_q.
- Exactly one event per press, regardless of hold time.

Acceptance (evaluated in the event cycle):
- write accepted = wr_evt & (state != FULL), or wr_evt & rd_evt when state == FULL (read frees a slot the same cycle).
- read accepted = rd_evt & (state != EMPTY).
- Rejected write sets ovf; rejected read sets udf. Both flags stay set until clr.

Strobes:
- wr_en/re_en are registered and high for exactly one cycle: the cycle after the event.
- w_addr/r_addr hold the target address throughout the strobe cycle.
- Latency: button edge sampled in cycle n -> strobe in cycle n+1.

Pointer update:
- At the clock edge that ends a strobe cycle, the strobed pointer increments modulo 2**W (2**W-1 wraps to 0).
- count, full and empty update on that same edge.

Simultaneous accepted read and write:
- Both strobes assert in the same cycle; both pointers advance; count is unchanged.
- reg_file read-during-write on different addresses is legal.
- When EMPTY, only the write is accepted; the read is rejected and udf is set.
- When FULL, both are accepted.

FSM (2-bit), with next state computed from count_next:
- EMPTY (00) -> NORMAL on a write-only.
- NORMAL (01) -> EMPTY when count_next == 0; -> FULL when count_next == 2**W; otherwise stays NORMAL.
- FULL (11) -> NORMAL on a read-only; stays FULL on read+write.
- full and empty decode from the state register and must match count at all times.
- Any illegal state encoding (10) recovers to EMPTY on the next clock.

No combinational path from wr_req/rd_req to any output.

Decomposition:
- Shared package fifo_pkg: state encodings EMPTY=2'b00, NORMAL=2'b01, FULL=2'b11; default widths B=8, W=3.
- One sub-module: rise_pulse (req, req_q register, pulse output, clr-load behaviour), instantiated twice.
- Pointer, count and FSM logic stay in fifo_ctrl.

Test Plan:
- Reset/idle: assert clr for 2 cycles with both buttons low -> all outputs at reset values, empty=1, no strobes for 20 cycles.
- Fill and wrap (W=3): 8 write presses (each held 5 cycles) -> exactly 8 wr_en pulses at w_addr 0..7, full=1, count=8, w_addr back at 0. A 9th press -> no wr_en, ovf=1, count stays 8.
- Drain: from full, 8 read presses -> re_en at r_addr 0..7, empty=1 after the 8th. A 9th press -> no re_en, udf=1.
- Simultaneous edges:
  - count=3: both buttons rise in the same cycle -> wr_en and re_en in the same cycle, count stays 3, both pointers +1.
  - Empty: both rise together -> write only, count=1, udf=1.
  - Full: both rise together -> both strobes, count stays 8.
- Held button across reset: wr_req held high, clr pulsed mid-hold -> no wr_en after clr until wr_req drops and rises again; then exactly one wr_en at w_addr=0.
- Long hold: wr_req held 100 cycles -> exactly one wr_en, 1 cycle after the rising edge.
